// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter; optional parity via FIFO_UART_TX_PARITY_EN
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
`ifdef FIFO_UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_d;
    logic                    bit_end;
    logic                    parity_q;

    assign bit_end = (baud_q == BAUD_LAST);
    assign busy    = (state_q != S_IDLE);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity of the popped byte is latched together with the data in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            parity_q <= (^fifo_dout) ^ parity_odd;
        end
    end
`else
    assign parity_q = 1'b1;
`endif

    // State, counters, shift register and the registered serial line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    // Next-state, counter updates, FIFO pop strobe and frame-done pulse
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;
        byte_done  = 1'b0;
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = fifo_dout;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        byte_done = 1'b1;
                        bit_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so tx lines up with the state register
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + PAR) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       tx, busy, byte_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0;
    int underflow = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] mem [0:15];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
`ifdef FIFO_UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) underflow++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr++;
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s start_bit: got none in 200 cycles, want tx=0", name);
        end
    endtask

    // Called with cycle 0 of the start bit already sampled; ends on the last stop cycle
    task automatic check_frame(input string name, input logic [7:0] d, input logic par, input int drop_at);
        logic exp_tx, exp_done;
        int b;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            if (i == drop_at) tx_enable = 1'b0;
            b = i / CPB;
            if (b == 0) exp_tx = 1'b0;
            else if (b <= 8) exp_tx = d[b-1];
            else if (PAR == 1 && b == 9) exp_tx = par;
            else exp_tx = 1'b1;
            exp_done = (i == FRAME - 1);
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++;
                $display("FAIL %s tx[%0d]: got %b want %b", name, i, tx, exp_tx);
            end
            vectors++;
            if (byte_done !== exp_done) begin
                miscompares++;
                $display("FAIL %s byte_done[%0d]: got %b want %b", name, i, byte_done, exp_done);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy[%0d]: got %b want 1", name, i, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_enable = 1'b0;
        step();
        step();
        vectors++;
        if ({tx, busy, fifo_rd_en, byte_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset outputs {tx,busy,rd_en,done}: got %b want 1000",
                     {tx, busy, fifo_rd_en, byte_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_empty();
        tx_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if ({tx, busy, fifo_rd_en} !== 3'b100) begin
                miscompares++;
                $display("FAIL idle_empty[%0d] {tx,busy,rd_en}: got %b want 100", i, {tx, busy, fifo_rd_en});
            end
        end
    endtask

    task automatic test_single_byte();
        int base;
        bit ok;
        base = rd_cnt;
        push(8'hA5);
        wait_start("single", ok);
        if (ok) check_frame("single_a5", 8'hA5, 1'b0, -1);
        step();
        vectors++;
        if ({tx, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_after {tx,busy}: got %b want 10", {tx, busy});
        end
        vectors++;
        if (rd_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL single_rd_en_cycles: got %0d want 1", rd_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base, gap;
        bit ok;
        base = rd_cnt;
        push(8'h00);
        push(8'hFF);
        wait_start("b2b", ok);
        if (ok) check_frame("b2b_00", 8'h00, 1'b0, -1);
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (tx === 1'b0) break;
            gap++;
        end
        vectors++;
        if (gap !== 3) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d want 3", gap);
        end
        if (tx === 1'b0) check_frame("b2b_ff", 8'hFF, 1'b0, -1);
        vectors++;
        if (rd_cnt - base !== 2) begin
            miscompares++;
            $display("FAIL b2b_pops: got %0d want 2", rd_cnt - base);
        end
        vectors++;
        if (fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_fifo_empty: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_enable_drop();
        int base;
        bit ok;
        base = rd_cnt;
        push(8'h3C);
        push(8'h5A);
        tx_enable = 1'b1;
        wait_start("drop", ok);
        if (ok) check_frame("drop_3c", 8'h3C, 1'b0, 4 * CPB);
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if ({tx, busy} !== 2'b10) begin
                miscompares++;
                $display("FAIL drop_idle[%0d] {tx,busy}: got %b want 10", i, {tx, busy});
            end
        end
        vectors++;
        if (rd_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL drop_pops: got %0d want 1", rd_cnt - base);
        end
        vectors++;
        if (fifo_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_fifo_empty: got %b want 0", fifo_empty);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit ok;
        tx_enable = 1'b1;
        wait_start("rstmid", ok);
        for (int i = 0; i < 12; i++) step();
        push(8'h81);
        step();
        rst = 1'b1;
        step();
        vectors++;
        if ({tx, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_abort {tx,busy}: got %b want 10", {tx, busy});
        end
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n++;
            if (tx === 1'b0) break;
        end
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL rstmid_restart_latency: got %0d want 3", n);
        end
        if (tx === 1'b0) check_frame("rstmid_81", 8'h81, 1'b0, -1);
        vectors++;
        if (fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_fifo_empty: got %b want 1", fifo_empty);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        bit ok;
        tx_enable = 1'b1;
        parity_odd = 1'b0;
        push(8'hA5);
        wait_start("par_a5_even", ok);
        if (ok) check_frame("par_a5_even", 8'hA5, 1'b0, -1);
        parity_odd = 1'b0;
        push(8'h07);
        wait_start("par_07_even", ok);
        if (ok) check_frame("par_07_even", 8'h07, 1'b1, -1);
        parity_odd = 1'b1;
        push(8'h07);
        wait_start("par_07_odd", ok);
        if (ok) check_frame("par_07_odd", 8'h07, 1'b0, -1);
        parity_odd = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_empty();
        test_single_byte();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        vectors++;
        if (underflow !== 0) begin
            miscompares++;
            $display("FAIL underflow_pops: got %0d want 0", underflow);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
